// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and fetch-stage types.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;
  localparam logic [3:0] AND = 4'h2;
  localparam logic [3:0] OR  = 4'h3;
  localparam logic [3:0] XOR = 4'h4;
  localparam logic [3:0] SHL = 4'h5;
  localparam logic [3:0] SHR = 4'h6;
  localparam logic [3:0] LD  = 4'h7;
  localparam logic [3:0] ST  = 4'h8;
  localparam logic [3:0] LDI = 4'h9;
  localparam logic [3:0] BEQ = 4'hA;
  localparam logic [3:0] BNE = 4'hB;
  localparam logic [3:0] JAL = 4'hC;
  localparam logic [3:0] JR  = 4'hD;
  localparam logic [3:0] NOP = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
  } fetch_entry_t;

  function automatic logic [3:0] opcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry decode buffer holding {pc, instr}; flush empties it, push+pop when full is legal.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // When full, the slot written is the one being popped this cycle.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, decode FIFO, redirect and HLT.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            dec_ready,
  output logic            halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     fetch_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] tag, tag_nxt;
  logic            outstanding, outstanding_nxt;
  logic            stale, stale_nxt;

  logic            fifo_push, fifo_pop, fifo_flush;
  fetch_entry_t    fifo_din, fifo_dout;
  logic [1:0]      fifo_count;

  logic            accept;
  logic            resp;
  logic            do_redirect;
  logic [2:0]      inflight;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    instr_valid = (fifo_count != 2'd0);
    instr       = fifo_dout.instr;
    instr_pc    = fifo_dout.pc;
    imem_addr   = pc;
    halted      = (state == HALTED);
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    tag_nxt         = tag;
    outstanding_nxt = outstanding;
    stale_nxt       = stale;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;
    fifo_din        = '{pc: tag, instr: imem_rdata};
    imem_req        = 1'b0;

    accept      = instr_valid && dec_ready;
    resp        = imem_rvalid && outstanding;
    do_redirect = redirect && ((state == FETCH) || (state == HALT_PEND));
    inflight    = {1'b0, fifo_count} + {2'b00, outstanding};

    if (resp) begin
      outstanding_nxt = 1'b0;
      stale_nxt       = 1'b0;
    end

    if (state == IDLE) begin
      state_nxt = FETCH;
    end else if (do_redirect) begin
      // A read still in flight is marked stale; one returning this cycle is simply dropped.
      fifo_flush = 1'b1;
      pc_nxt     = redirect_pc;
      state_nxt  = FETCH;
      if (outstanding && !resp) stale_nxt = 1'b1;
    end else begin
      fifo_pop = accept;
      if (resp && !stale) begin
        fifo_push = 1'b1;
        if (opcode(imem_rdata) == HLT) state_nxt = HALT_PEND;
      end
      if ((state == HALT_PEND) && accept && (opcode(fifo_dout.instr) == HLT))
        state_nxt = HALTED;
      if ((state == FETCH) && !outstanding && (inflight < FIFO_DEPTH[2:0])) begin
        imem_req        = 1'b1;
        tag_nxt         = pc;
        pc_nxt          = pc + 16'd1;
        outstanding_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tag         <= '0;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      tag         <= tag_nxt;
      outstanding <= outstanding_nxt;
      stale       <= stale_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (state != HALTED) begin
      if (accept) fetch_cnt <= fetch_cnt + 16'd1;
      if (instr_valid && !dec_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        dec_ready;
  logic        halted;

  logic        req2;
  logic [15:0] addr2;
  logic        rvalid2;
  logic [15:0] rdata2;
  logic        valid2;
  logic [15:0] instr2;
  logic [15:0] pc2;
  logic        halted2;
  logic        redirect2;
  logic [15:0] redirect_pc2;
  logic        ready2;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .dec_ready   (dec_ready),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .FIFO_DEPTH(2)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_rvalid (rvalid2),
    .imem_rdata  (rdata2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .instr_valid (valid2),
    .instr       (instr2),
    .instr_pc    (pc2),
    .dec_ready   (ready2),
    .halted      (halted2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt2),
    .stall_cnt   (stall_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for the main instance: latency in cycles from request to rvalid.
  logic [15:0] mem [256];
  int          lat;
  logic        busy;
  int          cnt;
  logic [15:0] maddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      busy        <= 1'b0;
      cnt         <= 0;
      maddr       <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem[imem_addr[7:0]];
        end else begin
          busy  <= 1'b1;
          maddr <= imem_addr;
          cnt   <= lat - 1;
        end
      end else if (busy) begin
        if (cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem[maddr[7:0]];
          busy        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid2 <= 1'b0;
    else        rvalid2 <= req2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic found;
    logic seen8;

    rst_n        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    dec_ready    = 1'b1;
    redirect2    = 1'b0;
    redirect_pc2 = '0;
    ready2       = 1'b1;
    rdata2       = 16'h1000;
    lat          = 1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0]    = 16'h1234;
    mem[1]    = 16'h2345;
    mem[7]    = 16'hF000;
    mem[8'h40] = 16'h5A40;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",     imem_req,    0);
    check("rst_addr",    imem_addr,   16'h0000);
    check("rst_valid",   instr_valid, 0);
    check("rst_instr",   instr,       0);
    check("rst_ipc",     instr_pc,    0);
    check("rst_halted",  halted,      0);
    check("rst_addr2",   addr2,       16'hFFFF);

    // Streaming with 1-cycle memory
    lat = 1; dec_ready = 1'b1;
    do_reset();
    check("t1_c0_req", imem_req, 0);
    step();
    check("t1_c1_req", imem_req, 1);
    check("t1_c1_addr", imem_addr, 16'h0000);
    step();
    check("t1_c2_req", imem_req, 0);
    check("t1_c2_valid", instr_valid, 0);
    step();
    check("t1_c3_valid", instr_valid, 1);
    check("t1_c3_instr", instr, 16'h1234);
    check("t1_c3_ipc", instr_pc, 16'h0000);
    check("t1_c3_req", imem_req, 1);
    check("t1_c3_addr", imem_addr, 16'h0001);
    step();
    check("t1_c4_valid", instr_valid, 0);
    step();
    check("t1_c5_instr", instr, 16'h2345);
    check("t1_c5_ipc", instr_pc, 16'h0001);
    check("t1_c5_addr", imem_addr, 16'h0002);

    // Decode stall: two words buffered, fetch stops, head held
    lat = 1; dec_ready = 1'b0;
    do_reset();
    repeat (5) step();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_req", imem_req, 0);
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_instr", instr, 16'h1234);
      check("t2_hold_ipc", instr_pc, 16'h0000);
      if (i < 4) step();
    end
    dec_ready = 1'b1;
    step();
    check("t2_drain1_instr", instr, 16'h2345);
    check("t2_drain1_ipc", instr_pc, 16'h0001);
    check("t2_drain1_req", imem_req, 1);
    check("t2_drain1_addr", imem_addr, 16'h0002);
`ifdef FETCH_PERF_CNT_EN
    check("t2_stall_cnt", stall_cnt, 16'd6);
`endif
    step();
    check("t2_gap_valid", instr_valid, 0);
    step();
    check("t2_drain2_instr", instr, 16'h1002);
    check("t2_drain2_ipc", instr_pc, 16'h0002);

    // Redirect with a read outstanding at addr 5 (3-cycle memory)
    lat = 3; dec_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0005) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_req5_seen", found, 1);
    dec_ready = 1'b0;
    step();
    check("t3_head_before", instr_valid, 1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    check("t3_redir_req", imem_req, 0);
    step();
    redirect = 1'b0;
    #1;
    check("t3_flushed", instr_valid, 0);
    check("t3_wait_stale", imem_req, 0);
    dec_ready = 1'b1;
    step();
    check("t3_stale_req", imem_req, 0);
    step();
    check("t3_stale_dropped", instr_valid, 0);
    check("t3_new_req", imem_req, 1);
    check("t3_new_addr", imem_addr, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_valid_seen", found, 1);
    check("t3_ipc", instr_pc, 16'h0040);
    check("t3_instr", instr, 16'h5A40);

    // HLT at pc 7 with decode always ready
    lat = 1; dec_ready = 1'b1;
    do_reset();
    found = 1'b0; seen8 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0008) seen8 = 1'b1;
      if (instr_valid && instr == 16'hF000) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_hlt_seen", found, 1);
    check("t4_hlt_ipc", instr_pc, 16'h0007);
    check("t4_pre_halted", halted, 0);
    step();
    check("t4_halted", halted, 1);
    check("t4_empty", instr_valid, 0);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req) seen8 = 1'b1;
      check("t4_still_halted", halted, 1);
      step();
    end
    check("t4_no_req_after", seen8, 0);

    // HLT sitting in the FIFO, redirected away before decode takes it
    lat = 1; dec_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (instr_valid && instr == 16'hF000) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_hlt_seen", found, 1);
    dec_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0010;
    #1;
    check("t5_redir_req", imem_req, 0);
    step();
    redirect = 1'b0;
    #1;
    check("t5_flushed", instr_valid, 0);
    check("t5_not_halted", halted, 0);
    check("t5_req", imem_req, 1);
    check("t5_addr", imem_addr, 16'h0010);
    dec_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_valid_seen", found, 1);
    check("t5_ipc", instr_pc, 16'h0010);
    check("t5_instr", instr, 16'h1010);
    check("t5_halted_low", halted, 0);

    // PC wrap on the RESET_PC=16'hFFFF instance
    do_reset();
    check("t6_c0_req", req2, 0);
    check("t6_c0_addr", addr2, 16'hFFFF);
    step();
    check("t6_c1_req", req2, 1);
    check("t6_c1_addr", addr2, 16'hFFFF);
    step();
    check("t6_c2_req", req2, 0);
    step();
    check("t6_c3_req", req2, 1);
    check("t6_c3_addr", addr2, 16'h0000);
    check("t6_c3_ipc", pc2, 16'hFFFF);
    step();
    step();
    check("t6_c5_ipc", pc2, 16'h0000);
    step();
`ifdef FETCH_PERF_CNT_EN
    check("t6_fetch_cnt", fetch_cnt2, 16'd2);
`endif
    check("t6_c6_valid", valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
